vend_change_sequencer: RTL and testbench

- Change-return controller for the vending machine. After a sale, the vend FSM hands it a change amount in cents.
- It sequences one-coin-at-a-time dispense commands to the quarter, dime and nickel tubes. Coin selection is greedy, with fallback when a tube is empty.
- Each dispense uses a command/acknowledge handshake with a timeout.
- Keeps per-tube inventory counters, refillable by the service port.

---
 rtl/vend_change_sequencer_if.sv | 39 +++
 rtl/vend_change_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_vend_change_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_change_sequencer_if.sv
// Bundle of the change request, refill, dispense and status signals between
// the vend controller (master) and the change sequencer (slave).
interface vend_change_sequencer_if #(
  parameter int AMT_W = 8,
  parameter int CNT_W = 6
);
  // Request handshake: a request transfers on a rising clock edge where
  // req_valid and req_ready are both high; the master holds req_amount
  // stable while req_valid is high and may drop req_valid after the transfer.
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             load_valid;
  logic [1:0]       load_tube;
  logic [CNT_W-1:0] load_count;
  logic [2:0]       disp;
  logic             disp_ack;
  logic             done;
  logic [AMT_W-1:0] shortfall;
  logic             fault;
  logic             busy;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_n;
  logic             exact_change_only;
  logic [2:0]       dbg_state;

  modport master (
    output req_valid, req_amount, load_valid, load_tube, load_count, disp_ack,
    input  req_ready, disp, done, shortfall, fault, busy,
    input  cnt_q, cnt_d, cnt_n, exact_change_only, dbg_state
  );

  modport slave (
    input  req_valid, req_amount, load_valid, load_tube, load_count, disp_ack,
    output req_ready, disp, done, shortfall, fault, busy,
    output cnt_q, cnt_d, cnt_n, exact_change_only, dbg_state
  );
endinterface

// File: rtl/vend_change_sequencer.sv
// Greedy coin-by-coin change dispenser with per-tube inventory and ack timeout.
// Optional exact-change indicator enabled by macro VEND_EXACT_CHANGE_EN.
module vend_change_sequencer #(
  parameter int AMT_W       = 8,
  parameter int CNT_W       = 6,
  parameter int INIT_Q      = 10,
  parameter int INIT_D      = 10,
  parameter int INIT_N      = 10,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  vend_change_sequencer_if.slave bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(25);
  localparam logic [AMT_W-1:0] VAL_D = AMT_W'(10);
  localparam logic [AMT_W-1:0] VAL_N = AMT_W'(5);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_FIRE     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  state_t           r_state,     w_state_next;
  logic [AMT_W-1:0] r_remaining, w_remaining_next;
  logic [2:0]       r_coin,      w_coin_next;
  logic [TW-1:0]    r_timer,     w_timer_next;
  logic [CNT_W-1:0] r_cnt_q,     w_cnt_q_next;
  logic [CNT_W-1:0] r_cnt_d,     w_cnt_d_next;
  logic [CNT_W-1:0] r_cnt_n,     w_cnt_n_next;
  logic [AMT_W-1:0] r_shortfall, w_shortfall_next;
  logic             r_fault,     w_fault_next;
  logic [CNT_W:0]   w_load_sum;
  logic [CNT_W-1:0] w_load_sat;
  logic [CNT_W-1:0] w_load_base;
  logic [AMT_W-1:0] w_coin_value;

  always_comb begin
    w_load_base = r_cnt_n;
    case (bus.load_tube)
      2'd1:    w_load_base = r_cnt_d;
      2'd2:    w_load_base = r_cnt_q;
      default: w_load_base = r_cnt_n;
    endcase
    w_load_sum = {1'b0, w_load_base} + {1'b0, bus.load_count};
    w_load_sat = w_load_sum[CNT_W] ? CNT_MAX : w_load_sum[CNT_W-1:0];
  end

  always_comb begin
    w_coin_value = '0;
    case (r_coin)
      3'b100:  w_coin_value = VAL_Q;
      3'b010:  w_coin_value = VAL_D;
      3'b001:  w_coin_value = VAL_N;
      default: w_coin_value = '0;
    endcase
  end

  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_coin_next      = r_coin;
    w_timer_next     = r_timer;
    w_cnt_q_next     = r_cnt_q;
    w_cnt_d_next     = r_cnt_d;
    w_cnt_n_next     = r_cnt_n;
    w_shortfall_next = r_shortfall;
    w_fault_next     = r_fault;
    case (r_state)
      S_IDLE: begin
        // A request in the same cycle as a refill takes priority; the refill is lost.
        if (bus.req_valid) begin
          w_remaining_next = bus.req_amount;
          w_state_next     = S_SELECT;
        end else if (bus.load_valid) begin
          case (bus.load_tube)
            2'd0:    w_cnt_n_next = w_load_sat;
            2'd1:    w_cnt_d_next = w_load_sat;
            2'd2:    w_cnt_q_next = w_load_sat;
            default: ;
          endcase
        end
      end
      S_SELECT: begin
        if (r_remaining >= VAL_Q && r_cnt_q != '0) begin
          w_coin_next  = 3'b100;
          w_state_next = S_FIRE;
        end else if (r_remaining >= VAL_D && r_cnt_d != '0) begin
          w_coin_next  = 3'b010;
          w_state_next = S_FIRE;
        end else if (r_remaining >= VAL_N && r_cnt_n != '0) begin
          w_coin_next  = 3'b001;
          w_state_next = S_FIRE;
        end else begin
          w_shortfall_next = r_remaining;
          w_fault_next     = 1'b0;
          w_state_next     = S_FINISH;
        end
      end
      S_FIRE: begin
        w_timer_next = '0;
        w_state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // Ack is checked before the timeout so a last-cycle ack still counts.
        if (bus.disp_ack) begin
          w_remaining_next = r_remaining - w_coin_value;
          if (r_coin[2] && r_cnt_q != '0) w_cnt_q_next = r_cnt_q - 1'b1;
          if (r_coin[1] && r_cnt_d != '0) w_cnt_d_next = r_cnt_d - 1'b1;
          if (r_coin[0] && r_cnt_n != '0) w_cnt_n_next = r_cnt_n - 1'b1;
          w_state_next = S_SELECT;
        end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
          w_shortfall_next = r_remaining;
          w_fault_next     = 1'b1;
          w_state_next     = S_FINISH;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_coin      <= '0;
      r_timer     <= '0;
      r_cnt_q     <= CNT_W'(INIT_Q);
      r_cnt_d     <= CNT_W'(INIT_D);
      r_cnt_n     <= CNT_W'(INIT_N);
      r_shortfall <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_coin      <= w_coin_next;
      r_timer     <= w_timer_next;
      r_cnt_q     <= w_cnt_q_next;
      r_cnt_d     <= w_cnt_d_next;
      r_cnt_n     <= w_cnt_n_next;
      r_shortfall <= w_shortfall_next;
      r_fault     <= w_fault_next;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.disp      = (r_state == S_FIRE) ? r_coin : 3'b000;
  assign bus.done      = (r_state == S_FINISH);
  assign bus.shortfall = r_shortfall;
  assign bus.fault     = r_fault;
  assign bus.cnt_q     = r_cnt_q;
  assign bus.cnt_d     = r_cnt_d;
  assign bus.cnt_n     = r_cnt_n;
  assign bus.dbg_state = r_state;

`ifdef VEND_EXACT_CHANGE_EN
  localparam logic [CNT_W-1:0] INIT_N_C = CNT_W'(INIT_N);
  localparam logic [CNT_W-1:0] INIT_D_C = CNT_W'(INIT_D);
  localparam logic EXACT_INIT = (INIT_N_C == '0) || (INIT_D_C == '0 && INIT_N_C < CNT_W'(2));
  logic r_exact;
  logic w_exact_next;

  // Tracks the counters as they will be after this edge, so it never lags a refill or dispense.
  assign w_exact_next = (w_cnt_n_next == '0) ||
                        (w_cnt_d_next == '0 && w_cnt_n_next < CNT_W'(2));

  always_ff @(posedge clk) begin
    if (rst) r_exact <= EXACT_INIT;
    else     r_exact <= w_exact_next;
  end

  assign bus.exact_change_only = r_exact;
`else
  assign bus.exact_change_only = 1'b0;
`endif

endmodule

// File: tb/tb_vend_change_sequencer.sv
// Directed bench for vend_change_sequencer: three instances with different tube
// initial counts, a vector table for whole transactions, and hand-written corner cases.
module tb_vend_change_sequencer;

`ifdef VEND_EXACT_CHANGE_EN
  localparam int EXACT_ON = 1;
`else
  localparam int EXACT_ON = 0;
`endif

  logic clk;
  logic rst;

  // Instance 0: defaults; 1: no quarters; 2: no dimes and no nickels.
  vend_change_sequencer_if #(.AMT_W(8), .CNT_W(6)) if_a ();
  vend_change_sequencer_if #(.AMT_W(8), .CNT_W(6)) if_b ();
  vend_change_sequencer_if #(.AMT_W(8), .CNT_W(6)) if_c ();

  vend_change_sequencer #(.INIT_Q(10), .INIT_D(10), .INIT_N(10)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  vend_change_sequencer #(.INIT_Q(0),  .INIT_D(10), .INIT_N(10)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  vend_change_sequencer #(.INIT_Q(10), .INIT_D(0),  .INIT_N(0))  dut_c (.clk(clk), .rst(rst), .bus(if_c));

  logic       req_valid_v [3];
  logic       load_valid_v[3];
  logic       ack_en      [3];
  logic       ack_man     [3];
  logic       ack_r       [3];
  logic [7:0] req_amount;
  logic [1:0] load_tube;
  logic [5:0] load_count;

  assign if_a.req_valid  = req_valid_v[0];
  assign if_b.req_valid  = req_valid_v[1];
  assign if_c.req_valid  = req_valid_v[2];
  assign if_a.load_valid = load_valid_v[0];
  assign if_b.load_valid = load_valid_v[1];
  assign if_c.load_valid = load_valid_v[2];
  assign if_a.disp_ack   = ack_r[0] | ack_man[0];
  assign if_b.disp_ack   = ack_r[1] | ack_man[1];
  assign if_c.disp_ack   = ack_r[2] | ack_man[2];
  assign if_a.req_amount = req_amount;
  assign if_b.req_amount = req_amount;
  assign if_c.req_amount = req_amount;
  assign if_a.load_tube  = load_tube;
  assign if_b.load_tube  = load_tube;
  assign if_c.load_tube  = load_tube;
  assign if_a.load_count = load_count;
  assign if_b.load_count = load_count;
  assign if_c.load_count = load_count;

  typedef struct {
    logic [2:0] disp;
    logic       done;
    logic [7:0] sf;
    logic       fault;
    logic [5:0] q, d, n;
    logic       busy, ready, exact;
  } obs_t;

  function automatic obs_t obs(input int k);
    obs_t o;
    case (k)
      0: begin
        o.disp = if_a.disp; o.done = if_a.done; o.sf = if_a.shortfall; o.fault = if_a.fault;
        o.q = if_a.cnt_q; o.d = if_a.cnt_d; o.n = if_a.cnt_n;
        o.busy = if_a.busy; o.ready = if_a.req_ready; o.exact = if_a.exact_change_only;
      end
      1: begin
        o.disp = if_b.disp; o.done = if_b.done; o.sf = if_b.shortfall; o.fault = if_b.fault;
        o.q = if_b.cnt_q; o.d = if_b.cnt_d; o.n = if_b.cnt_n;
        o.busy = if_b.busy; o.ready = if_b.req_ready; o.exact = if_b.exact_change_only;
      end
      default: begin
        o.disp = if_c.disp; o.done = if_c.done; o.sf = if_c.shortfall; o.fault = if_c.fault;
        o.q = if_c.cnt_q; o.d = if_c.cnt_d; o.n = if_c.cnt_n;
        o.busy = if_c.busy; o.ready = if_c.req_ready; o.exact = if_c.exact_change_only;
      end
    endcase
    return o;
  endfunction

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dispenser model: acknowledges one cycle after each dispense pulse when enabled.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) ack_r[k] <= 1'b0;
      else     ack_r[k] <= ack_en[k] && (obs(k).disp != 3'b000);
    end
  end

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q[$];
  logic [4:0] got_q[$];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (obs(k).disp != 3'b000) got_q.push_back({k[1:0], obs(k).disp});
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_req(input int k, input int amount);
    @(negedge clk);
    req_amount     = amount[7:0];
    req_valid_v[k] = 1'b1;
    @(negedge clk);
    req_valid_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output logic [7:0] sf, output logic flt, output bit ok);
    ok  = 1'b0;
    sf  = '0;
    flt = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (obs(k).done) begin
        ok  = 1'b1;
        sf  = obs(k).sf;
        flt = obs(k).fault;
        break;
      end
    end
  endtask

  task automatic do_load(input int k, input int tube, input int count);
    @(negedge clk);
    load_tube       = tube[1:0];
    load_count      = count[5:0];
    load_valid_v[k] = 1'b1;
    @(negedge clk);
    load_valid_v[k] = 1'b0;
  endtask

  task automatic chk_counts(input string tag, input int k, input int q, input int d, input int n);
    chk({tag, "_cnt_q"}, obs(k).q, q);
    chk({tag, "_cnt_d"}, obs(k).d, d);
    chk({tag, "_cnt_n"}, obs(k).n, n);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          inst;
    int          amount;
    logic        ack;
    logic [14:0] seq;   // up to five one-hot coins, first coin in the top bits
    int          sf;
    int          flt;
    int          q, d, n;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] sf;
    logic       flt;
    bit         ok;
    logic [2:0] cc;
    string      tag;
    tag = $sformatf("vec%0d", idx);
    got_q.delete();
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      cc = v.seq[14 - 3*c -: 3];
      if (cc != 3'b000) exp_q.push_back({v.inst[1:0], cc});
    end
    ack_en[v.inst] = v.ack;
    run_req(v.inst, v.amount);
    wait_done(v.inst, sf, flt, ok);
    chk({tag, "_done_seen"}, int'(ok), 1);
    chk({tag, "_shortfall"}, sf, v.sf);
    chk({tag, "_fault"}, flt, v.flt);
    chk_counts(tag, v.inst, v.q, v.d, v.n);
    chk({tag, "_coin_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk({tag, "_coin"}, got_q.pop_front(), exp_q.pop_front());
    end
  endtask

  localparam logic [2:0] CQ = 3'b100;
  localparam logic [2:0] CD = 3'b010;
  localparam logic [2:0] CN = 3'b001;
  localparam logic [2:0] C0 = 3'b000;

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] sf;
    logic       flt;
    bit         ok;
    int         cyc;

    rst        = 1'b1;
    req_amount = '0;
    load_tube  = '0;
    load_count = '0;
    for (int k = 0; k < 3; k++) begin
      req_valid_v[k]  = 1'b0;
      load_valid_v[k] = 1'b0;
      ack_en[k]       = 1'b0;
      ack_man[k]      = 1'b0;
    end

    vecs[0] = '{0, 40,  1'b1, {CQ, CD, CN, C0, C0},  0, 0, 9, 9, 9};
    vecs[1] = '{0, 27,  1'b1, {CQ, C0, C0, C0, C0},  2, 0, 8, 9, 9};
    vecs[2] = '{0, 0,   1'b1, {C0, C0, C0, C0, C0},  0, 0, 8, 9, 9};
    vecs[3] = '{0, 3,   1'b1, {C0, C0, C0, C0, C0},  3, 0, 8, 9, 9};
    vecs[4] = '{1, 30,  1'b1, {CD, CD, CD, C0, C0},  0, 0, 0, 7, 10};
    vecs[5] = '{1, 45,  1'b1, {CD, CD, CD, CD, CN},  0, 0, 0, 3, 9};
    vecs[6] = '{2, 35,  1'b1, {CQ, C0, C0, C0, C0}, 10, 0, 9, 0, 0};
    vecs[7] = '{0, 25,  1'b0, {CQ, C0, C0, C0, C0}, 25, 1, 8, 9, 9};
    vecs[8] = '{0, 5,   1'b1, {CN, C0, C0, C0, C0},  0, 0, 8, 9, 8};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", obs(0).ready, 1);
    chk("rst_busy", obs(0).busy, 0);
    chk("rst_done", obs(0).done, 0);
    chk("rst_disp", obs(0).disp, 0);
    chk("rst_shortfall", obs(0).sf, 0);
    chk("rst_fault", obs(0).fault, 0);
    chk_counts("rst_a", 0, 10, 10, 10);
    chk_counts("rst_b", 1, 0, 10, 10);
    chk("rst_exact_a", obs(0).exact, 0);
    chk("rst_exact_c", obs(2).exact, EXACT_ON);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Timeout takes exactly ACK_TIMEOUT wait cycles: done shows 16 cycles after the pulse.
    ack_en[0] = 1'b0;
    run_req(0, 25);
    @(negedge clk);
    chk("to_first_disp", obs(0).disp, 3'b100);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (obs(0).done) begin
        cyc = i;
        ok  = 1'b1;
        break;
      end
    end
    chk("to_done_latency", cyc, 16);
    chk("to_fault", obs(0).fault, 1);
    chk("to_shortfall", obs(0).sf, 25);
    chk_counts("to", 0, 8, 9, 8);

    // Ack in the very cycle the timer expires is a normal ack.
    run_req(0, 25);
    @(negedge clk);
    chk("late_ack_disp", obs(0).disp, 3'b100);
    repeat (15) @(negedge clk);
    ack_man[0] = 1'b1;
    @(negedge clk);
    ack_man[0] = 1'b0;
    wait_done(0, sf, flt, ok);
    chk("late_ack_done_seen", int'(ok), 1);
    chk("late_ack_fault", flt, 0);
    chk("late_ack_shortfall", sf, 0);
    chk_counts("late_ack", 0, 7, 9, 8);

    // Reset in the middle of WAIT_ACK abandons the coin.
    run_req(0, 25);
    repeat (5) @(negedge clk);
    chk("midrst_busy_before", obs(0).busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", obs(0).busy, 0);
    chk("midrst_ready", obs(0).ready, 1);
    chk("midrst_disp", obs(0).disp, 0);
    chk_counts("midrst", 0, 10, 10, 10);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", obs(0).done, 0);
    chk_counts("midrst_after", 0, 10, 10, 10);

    // Refills: saturation, ignored tube 3, ordinary add.
    do_load(0, 0, 60);
    chk_counts("load_sat", 0, 10, 10, 63);
    do_load(0, 3, 5);
    chk_counts("load_t3", 0, 10, 10, 63);
    do_load(0, 1, 3);
    chk_counts("load_d", 0, 10, 13, 63);

    // Load while busy is dropped.
    ack_en[0] = 1'b1;
    run_req(0, 5);
    do_load(0, 2, 5);
    wait_done(0, sf, flt, ok);
    chk("busy_load_done_seen", int'(ok), 1);
    chk("busy_load_shortfall", sf, 0);
    chk_counts("busy_load", 0, 10, 13, 62);

    // Request and load in the same IDLE cycle: request wins.
    got_q.delete();
    @(negedge clk);
    req_amount      = 8'd10;
    req_valid_v[0]  = 1'b1;
    load_tube       = 2'd2;
    load_count      = 6'd7;
    load_valid_v[0] = 1'b1;
    @(negedge clk);
    req_valid_v[0]  = 1'b0;
    load_valid_v[0] = 1'b0;
    wait_done(0, sf, flt, ok);
    chk("req_load_done_seen", int'(ok), 1);
    chk("req_load_shortfall", sf, 0);
    chk_counts("req_load", 0, 10, 12, 62);
    chk("req_load_coins", got_q.size(), 1);
    if (got_q.size() > 0) chk("req_load_coin", got_q[0], {2'd0, CD});

    // Exact-change indicator on the no-dime/no-nickel instance.
    chk("exact_c_before", obs(2).exact, EXACT_ON);
    do_load(2, 0, 5);
    chk("exact_c_after", obs(2).exact, 0);
    chk_counts("exact_c", 2, 10, 0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
